// File: rtl/ball_physics_step.sv
// Ball physics integrator: consumes {ax, ay, ctrl} frames and, on each tick,
// steps one ball through accel -> velocity -> position with velocity
// saturation and damped wall bounce. Outputs hold until the next step.
module ball_physics_step #(
    parameter int POS_W      = 10,
    parameter int FRAC_BITS  = 6,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int ACC_SHIFT  = 4,
    parameter int V_MAX      = 1024,
    parameter int DAMP_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_valid,
    input  logic [47:0]      frame_data,
    input  logic             tick,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [15:0]      vel_x,
    output logic [15:0]      vel_y,
    output logic             step_done,
    output logic             busy,
    output logic             overrun
);

    // Working position width: integer + fraction + sign + one overshoot bit
    localparam int PW = POS_W + FRAC_BITS + 2;
    localparam logic signed [PW-1:0] X_LIM = PW'(X_MAX * (2 ** FRAC_BITS));
    localparam logic signed [PW-1:0] Y_LIM = PW'(Y_MAX * (2 ** FRAC_BITS));
    localparam logic signed [PW-1:0] X_CTR = PW'(((X_MAX + 1) / 2) * (2 ** FRAC_BITS));
    localparam logic signed [PW-1:0] Y_CTR = PW'(((Y_MAX + 1) / 2) * (2 ** FRAC_BITS));
    localparam logic [POS_W-1:0] X_CTR_INT = POS_W'((X_MAX + 1) / 2);
    localparam logic [POS_W-1:0] Y_CTR_INT = POS_W'((Y_MAX + 1) / 2);
    localparam logic signed [16:0] V_LIM = 17'(V_MAX);

    typedef enum logic [2:0] {
        IDLE,
        VEL,
        POS,
        WALL,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [15:0] axLat_q, ayLat_q;
    logic [15:0]        ctrlLat_q;
    logic signed [15:0] axSnap_q, aySnap_q;
    logic               recenterSnap_q;
    logic signed [PW-1:0] pX_q, pY_q;
    logic signed [15:0] vX_q, vY_q;
    logic [POS_W-1:0]   posX_q, posY_q;
    logic [15:0]        velXOut_q, velYOut_q;
    logic               overrun_q;

    logic signed [PW-1:0] wallPX, wallPY;
    logic signed [15:0]   wallVX, wallVY;
    logic                 unusedCtrlBits;

    // Only the recenter bit of ctrl has a meaning today
    assign unusedCtrlBits = ^ctrlLat_q[15:1];

    // Add the shifted acceleration, then clamp to +/-V_MAX (17 bits cannot overflow)
    function automatic logic signed [15:0] velStep(input logic signed [15:0] v,
                                                   input logic signed [15:0] a);
        logic signed [15:0] dv;
        logic signed [16:0] sum;
        dv  = a >>> ACC_SHIFT;
        sum = 17'(v) + 17'(dv);
        if (sum > V_LIM) begin
            return 16'(V_LIM);
        end else if (sum < -V_LIM) begin
            return 16'(-V_LIM);
        end
        return sum[15:0];
    endfunction

    // Reverse direction and shed a fraction of the speed on a wall hit
    function automatic logic signed [15:0] bounceVel(input logic signed [15:0] v);
        logic signed [15:0] kept;
        kept = v - (v >>> DAMP_SHIFT);
        return -kept;
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one fixed walk through the pipeline, recenter skips the motion steps
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = VEL;
            VEL:     state_d = recenterSnap_q ? DONE : POS;
            POS:     state_d = WALL;
            WALL:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: busy/step_done decode the state, the rest come from holding registers
    always_comb begin
        busy      = (state_q != IDLE);
        step_done = (state_q == DONE);
        overrun   = overrun_q;
        pos_x     = posX_q;
        pos_y     = posY_q;
        vel_x     = velXOut_q;
        vel_y     = velYOut_q;
    end

    // Wall check on the freshly integrated position; exact wall hits do not bounce
    always_comb begin
        wallPX = pX_q;
        wallVX = vX_q;
        wallPY = pY_q;
        wallVY = vY_q;
        if (pX_q[PW-1]) begin
            wallPX = '0;
            wallVX = bounceVel(vX_q);
        end else if (pX_q > X_LIM) begin
            wallPX = X_LIM;
            wallVX = bounceVel(vX_q);
        end
        if (pY_q[PW-1]) begin
            wallPY = '0;
            wallVY = bounceVel(vY_q);
        end else if (pY_q > Y_LIM) begin
            wallPY = Y_LIM;
            wallVY = bounceVel(vY_q);
        end
    end

    // Datapath: frame latches, step snapshot, integration and output holding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            axLat_q        <= '0;
            ayLat_q        <= '0;
            ctrlLat_q      <= '0;
            axSnap_q       <= '0;
            aySnap_q       <= '0;
            recenterSnap_q <= 1'b0;
            pX_q           <= X_CTR;
            pY_q           <= Y_CTR;
            vX_q           <= '0;
            vY_q           <= '0;
            posX_q         <= X_CTR_INT;
            posY_q         <= Y_CTR_INT;
            velXOut_q      <= '0;
            velYOut_q      <= '0;
            overrun_q      <= 1'b0;
        end else begin
            if (frame_valid) begin
                axLat_q   <= frame_data[47:32];
                ayLat_q   <= frame_data[31:16];
                ctrlLat_q <= frame_data[15:0];
            end
            if (tick && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        axSnap_q       <= frame_valid ? frame_data[47:32] : axLat_q;
                        aySnap_q       <= frame_valid ? frame_data[31:16] : ayLat_q;
                        recenterSnap_q <= frame_valid ? frame_data[0]     : ctrlLat_q[0];
                    end
                end
                VEL: begin
                    if (recenterSnap_q) begin
                        pX_q      <= X_CTR;
                        pY_q      <= Y_CTR;
                        vX_q      <= '0;
                        vY_q      <= '0;
                        posX_q    <= X_CTR_INT;
                        posY_q    <= Y_CTR_INT;
                        velXOut_q <= '0;
                        velYOut_q <= '0;
                    end else begin
                        vX_q <= velStep(vX_q, axSnap_q);
                        vY_q <= velStep(vY_q, aySnap_q);
                    end
                end
                POS: begin
                    pX_q <= pX_q + PW'(vX_q);
                    pY_q <= pY_q + PW'(vY_q);
                end
                WALL: begin
                    pX_q      <= wallPX;
                    pY_q      <= wallPY;
                    vX_q      <= wallVX;
                    vY_q      <= wallVY;
                    posX_q    <= wallPX[POS_W+FRAC_BITS-1:FRAC_BITS];
                    posY_q    <= wallPY[POS_W+FRAC_BITS-1:FRAC_BITS];
                    velXOut_q <= wallVX;
                    velYOut_q <= wallVY;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
